device_uart_tx: RTL
===================

Name: device_uart_tx

Overview:
- Memory-mapped UART transmitter on the cluster's device bus. It sits downstream of the cluster's address decode (shared addresses 0xFC00-0xFFFF).
- Consumes device write/read strobes, buffers transmit bytes in a FIFO and serialises them as 8N1 on a single output pin.
- Returns registered read data on device_data_in the cycle after a read.
- Records the ID of the core that last queued a byte.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the transmit FIFO (power of two, at least 2).
- DEFAULT_DIVISOR, 16, clocks per serial bit after reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- device_core_id  input  4  binary ID of the core currently granted the bus.
- device_write_en  input  1  device write strobe, one cycle per access.
- device_read_en  input  1  device read strobe, one cycle per access.
- device_addr  input  10  device register address.
- device_data_out  input  16  write data from the cluster.
- device_data_in  output  16  read data to the cluster, registered.
- uart_tx  output  1  serial line; idle high.

Behaviour:
- Register map (device_addr):
  - 0x000 TX_DATA, W: push device_data_out[7:0] into the FIFO.
  - 0x001 STATUS, R: [15] overflow (sticky), [14] tx_active, [13] full, [12] empty, [$clog2(FIFO_DEPTH):0] FIFO count; all other bits 0.
  - 0x002 DIVISOR, R/W: 16-bit. A write of 0 is stored as 1.
  - 0x003 LAST_CORE, R: [3:0] core ID of the last accepted TX_DATA push; upper bits 0.
  - All other addresses read 0; writes to them are ignored.
- Read timing:
  - device_data_in is loaded on the clock edge where device_read_en=1, so data is valid the following cycle.
  - It holds its value until the next read.
- A STATUS read clears overflow on the same edge. The returned value shows the pre-clear state.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A rejected push sets overflow and leaves the FIFO and LAST_CORE unchanged.
  - An accepted push updates LAST_CORE to device_core_id.
- If write_en and read_en are both asserted in the same cycle, both take effect.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH. Full when count=FIFO_DEPTH; empty when count=0.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head byte into the shift register, latch DIVISOR into the bit-period register, and go to START. The pop takes effect on that edge.
  - START: uart_tx=0 for one bit period.
  - DATA: 8 bits, LSB first, each held one bit period.
  - STOP: uart_tx=1 for one bit period, then return to IDLE.
  - Back-to-back bytes: from STOP, the next START begins on the cycle after STOP ends. This is the one IDLE cycle, so the inter-frame gap is exactly 1 clock.
  - Frame length is 10*latched_divisor clocks. A DIVISOR write mid-frame affects only the next frame.
- tx_active=1 in every state except IDLE.
- Bit period: a 16-bit down-counter is loaded with divisor-1 at each bit start. The bit advances when the counter reaches 0.
- uart_tx is driven from a flop. The first START low appears the cycle after the pop edge.
- Reset (asserted, i.e. reset=0), applied asynchronously including mid-frame:
  - FIFO is emptied (count 0) and overflow is cleared.
  - DIVISOR=DEFAULT_DIVISOR, LAST_CORE=0, device_data_in=0.
  - FSM returns to IDLE and uart_tx=1 immediately.
  - A frame interrupted by reset is abandoned and not resumed.

Test Plan:
- Reset → uart_tx=1 and device_data_in=0. A STATUS read returns 0x1000 (empty, count 0). A DIVISOR read returns 16.
- Write DIVISOR=4, then TX_DATA=0x55 from core 5 → uart_tx reads, one bit per 4 clocks: 0, 1,0,1,0,1,0,1,0, 1. The frame lasts 40 clocks. LAST_CORE reads 5.
- Issue 9 TX_DATA writes (FIFO_DEPTH=8) with the FSM held busy at divisor 1000 → the first byte is popped, the queue then holds 8 bytes, and the 9th write is accepted. Issue a 10th write → STATUS=0xE008 (overflow, active, full, count 8). A second STATUS read then shows bit 15 = 0.
- Write DIVISOR=0 → it reads back 1. Queue 2 bytes → frames last 10 clocks each with a 1-clock gap between them, 21 clocks total.
- Assert read_en at cycle N for LAST_CORE → data appears on device_data_in at cycle N+1 and holds through N+5 with no further reads.
- Assert reset during bit 3 of a frame → uart_tx=1 asynchronously. After release, STATUS=0x1000 and no further frame is emitted.

Source files
------------

// File: rtl/device_uart_tx.sv
// rtl/device_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO
//
// Ports:
//   clk             system clock
//   reset           asynchronous active-low reset
//   device_core_id  ID of the core currently granted the bus
//   device_write_en write strobe, one cycle per access
//   device_read_en  read strobe, one cycle per access
//   device_addr     register address (0 TX_DATA, 1 STATUS, 2 DIVISOR, 3 LAST_CORE)
//   device_data_out write data from the cluster
//   device_data_in  registered read data, valid the cycle after a read
//   uart_tx         serial output, idle high
module device_uart_tx #(
  parameter int FIFO_DEPTH      = 8,
  parameter int DEFAULT_DIVISOR = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  device_core_id,
  input  logic        device_write_en,
  input  logic        device_read_en,
  input  logic [9:0]  device_addr,
  input  logic [15:0] device_data_out,
  output logic [15:0] device_data_in,
  output logic        uart_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic [15:0]      r_divisor;
  logic [3:0]       r_last_core;
  logic [15:0]      r_rdata;
  logic             r_tx;
  logic [15:0]      r_period, r_bit_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;

  logic [15:0]      w_period_nxt, w_cnt_nxt, w_rdata_nxt, w_status;
  logic [7:0]       w_shift_nxt;
  logic [2:0]       w_idx_nxt;
  logic             w_tx_nxt, w_pop, w_push, w_reject, w_full, w_empty;
  logic             w_tx_sel, w_status_rd, w_bit_done;

  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_tx_sel    = device_write_en && (device_addr == 10'h000);
  assign w_status_rd = device_read_en && (device_addr == 10'h001);
  // A full FIFO still accepts a push when the FSM pops on the same edge.
  assign w_push      = w_tx_sel && (!w_full || w_pop);
  assign w_reject    = w_tx_sel && w_full && !w_pop;
  assign w_bit_done  = (r_bit_cnt == 16'd0);
  assign uart_tx        = r_tx;
  assign device_data_in = r_rdata;

  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period;
    w_cnt_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_idx_nxt    = r_bit_idx;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_nxt  = S_START;
          w_period_nxt = r_divisor;
          w_cnt_nxt    = r_divisor - 16'd1;
          w_shift_nxt  = r_fifo[r_rd_ptr];
          w_tx_nxt     = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = r_period - 16'd1;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_bit_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt = r_period - 16'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt   = r_bit_idx + 3'd1;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_cnt_nxt = r_bit_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_bit_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_status           = '0;
    w_status[15]       = r_overflow;
    w_status[14]       = (r_state != S_IDLE);
    w_status[13]       = w_full;
    w_status[12]       = w_empty;
    w_status[PTR_W:0]  = r_count;
    case (device_addr)
      10'h001: w_rdata_nxt = w_status;
      10'h002: w_rdata_nxt = r_divisor;
      10'h003: w_rdata_nxt = {12'h000, r_last_core};
      default: w_rdata_nxt = 16'h0000;
    endcase
  end

  // FIFO storage needs no reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= device_data_out[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_divisor   <= 16'(DEFAULT_DIVISOR);
      r_last_core <= 4'd0;
      r_rdata     <= 16'h0000;
      r_tx        <= 1'b1;
      r_period    <= 16'(DEFAULT_DIVISOR);
      r_bit_cnt   <= 16'd0;
      r_shift     <= 8'h00;
      r_bit_idx   <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_period  <= w_period_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_idx_nxt;
      r_tx      <= w_tx_nxt;
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_last_core <= device_core_id;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // A rejected push in the same cycle as a STATUS read keeps overflow set.
      if (w_reject)         r_overflow <= 1'b1;
      else if (w_status_rd) r_overflow <= 1'b0;
      if (device_write_en && device_addr == 10'h002)
        r_divisor <= (device_data_out == 16'h0000) ? 16'h0001 : device_data_out;
      if (device_read_en) r_rdata <= w_rdata_nxt;
    end
  end

endmodule
